// File: rtl/jtopl_eg_pkg.sv
// Shared envelope-generator types and widths.
package jtopl_eg_pkg;
    typedef enum logic [1:0] {
        ATTACK  = 2'd0,
        DECAY   = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } eg_state_t;

    localparam int EG_CNT_W = 15;
    localparam int ATT_W    = 10;
    localparam int BRATE_W  = 5;
endpackage

// File: rtl/jtopl_eg_ctrl_if.sv
// Register-file-side inputs and step-calculator-side outputs of the EG controller.
interface jtopl_eg_ctrl_if;
    import jtopl_eg_pkg::*;

    logic                cen;
    logic                zero;
    logic                keyon;
    logic [3:0]          arate;
    logic [3:0]          drate;
    logic [3:0]          rrate;
    logic [3:0]          sl;
    logic                eg_type;
    logic [ATT_W-1:0]    eg_in;
    logic [1:0]          state_out;
    logic [BRATE_W-1:0]  base_rate;
    logic                attack;
    logic                keyon_edge;
    logic [EG_CNT_W-1:0] eg_cnt;

    modport master (
        output cen, zero, keyon, arate, drate, rrate, sl, eg_type, eg_in,
        input  state_out, base_rate, attack, keyon_edge, eg_cnt
    );

    modport slave (
        input  cen, zero, keyon, arate, drate, rrate, sl, eg_type, eg_in,
        output state_out, base_rate, attack, keyon_edge, eg_cnt
    );
endinterface

// File: rtl/jtopl_eg_slotmem.sv
// Slot-rotating storage: SLOTS-deep shift register advanced by cen.
module jtopl_eg_slotmem #(
    parameter int           SLOTS   = 18,
    parameter int           W       = 3,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cen,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [W-1:0] mem [SLOTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) mem[i] <= RST_VAL;
        end else if (cen) begin
            mem[0] <= din;
            for (int i = 1; i < SLOTS; i++) mem[i] <= mem[i-1];
        end
    end

    assign dout = mem[SLOTS-1];
endmodule

// File: rtl/jtopl_eg_ctrl.sv
// EG controller: per-slot ADSR next-state, rate selection and global envelope counter.
module jtopl_eg_ctrl
    import jtopl_eg_pkg::*;
#(
    parameter int SLOTS = 18
) (
    input  logic            clk,
    input  logic            rst,
    jtopl_eg_ctrl_if.slave  eg
);
    localparam logic [2:0]          SLOT_RST = {1'b0, RELEASE};
    localparam logic [EG_CNT_W-1:0] CNT_ONE  = 1;

    logic [2:0]  old_q;
    logic [2:0]  new_d;
    logic        prev_kon;
    logic        kon_edge;
    eg_state_t   st_old;
    eg_state_t   st_new;
    logic [3:0]  rate;
    logic [4:0]  slv;

    jtopl_eg_slotmem #(
        .SLOTS   (SLOTS),
        .W       (3),
        .RST_VAL (SLOT_RST)
    ) u_slotmem (
        .clk  (clk),
        .rst  (rst),
        .cen  (eg.cen),
        .din  (new_d),
        .dout (old_q)
    );

    always_comb begin
        prev_kon = old_q[2];
        st_old   = eg_state_t'(old_q[1:0]);
        slv      = (eg.sl == 4'hf) ? 5'h1f : {1'b0, eg.sl};
        st_new   = st_old;
        kon_edge = 1'b0;
        // Key transitions outrank level-driven progress.
        if (eg.keyon && !prev_kon) begin
            st_new   = ATTACK;
            kon_edge = 1'b1;
        end else if (!eg.keyon && prev_kon) begin
            st_new = RELEASE;
        end else if (st_old == ATTACK && eg.eg_in == '0) begin
            st_new = DECAY;
        end else if (st_old == DECAY && eg.eg_in[ATT_W-1 -: 5] >= slv) begin
            st_new = SUSTAIN;
        end

        rate = 4'd0;
        case (st_new)
            ATTACK:  rate = eg.arate;
            DECAY:   rate = eg.drate;
            SUSTAIN: rate = eg.eg_type ? 4'd0 : eg.rrate;
            RELEASE: rate = eg.rrate;
            default: rate = 4'd0;
        endcase

        new_d = {eg.keyon, st_new};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eg.state_out  <= RELEASE;
            eg.base_rate  <= '0;
            eg.attack     <= 1'b0;
            eg.keyon_edge <= 1'b0;
            eg.eg_cnt     <= '0;
        end else if (eg.cen) begin
            eg.state_out  <= st_new;
            eg.base_rate  <= (rate == 4'd0) ? '0 : {rate, 1'b0};
            eg.attack     <= (st_new == ATTACK);
            eg.keyon_edge <= kon_edge;
            if (eg.zero) eg.eg_cnt <= eg.eg_cnt + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_jtopl_eg_ctrl.sv
// Scoreboard bench for jtopl_eg_ctrl: directed per-round vectors on slot 5.
module tb_jtopl_eg_ctrl;
    typedef struct {
        bit          chk_out;
        bit          chk_cnt;
        logic [1:0]  st;
        logic [4:0]  br;
        logic        att;
        logic        ke;
        logic [14:0] cnt;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    exp_t last_e;
    int   n_chk = 0;
    int   n_err = 0;
    logic [14:0] cnt_exp = '0;

    jtopl_eg_ctrl_if eg();

    jtopl_eg_ctrl #(.SLOTS(18)) dut (
        .clk (clk),
        .rst (rst),
        .eg  (eg)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Monitor: outputs are registered, so sample just after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk_out) begin
                cmp({e.nm, ".state"},  32'(eg.state_out),  32'(e.st));
                cmp({e.nm, ".brate"},  32'(eg.base_rate),  32'(e.br));
                cmp({e.nm, ".attack"}, 32'(eg.attack),     32'(e.att));
                cmp({e.nm, ".kedge"},  32'(eg.keyon_edge), 32'(e.ke));
            end
            if (e.chk_cnt) cmp({e.nm, ".cnt"}, 32'(eg.eg_cnt), 32'(e.cnt));
        end
    end

    task automatic drive(input logic r, input logic c, input logic z, input logic k,
                         input logic [3:0] ar, input logic [3:0] dr, input logic [3:0] rr,
                         input logic [3:0] s, input logic et, input logic [9:0] ei,
                         input exp_t e);
        @(posedge clk);
        #2;
        rst = r; eg.cen = c; eg.zero = z; eg.keyon = k;
        eg.arate = ar; eg.drate = dr; eg.rrate = rr; eg.sl = s;
        eg.eg_type = et; eg.eg_in = ei;
        if (!r && c && z) cnt_exp = cnt_exp + 15'd1;
        e.cnt = cnt_exp;
        sb.push_back(e);
        last_e = e;
    endtask

    // One round of 18 slots; only slot 5 carries the test vector.
    task automatic round(input logic k, input logic [3:0] ar, input logic [3:0] dr,
                         input logic [3:0] rr, input logic [3:0] s, input logic et,
                         input logic [9:0] ei, input logic [1:0] st, input logic [4:0] br,
                         input logic ke, input bit hold, input string nm);
        exp_t e;
        for (int slot = 0; slot < 18; slot++) begin
            if (hold && slot == 5) begin
                e = last_e;
                e.nm = {nm, "_cen0"};
                drive(1'b0, 1'b0, 1'b1, 1'b1, 4'hf, 4'hf, 4'hf, 4'h0, 1'b0, 10'h0, e);
            end
            e.chk_out = 1; e.chk_cnt = 1;
            if (slot == 5) begin
                e.st = st; e.br = br; e.att = (st == 2'd0); e.ke = ke;
                e.nm = {nm, "_s5"};
                drive(1'b0, 1'b1, 1'b0, k, ar, dr, rr, s, et, ei, e);
            end else begin
                e.st = 2'd3; e.br = 5'd0; e.att = 1'b0; e.ke = 1'b0;
                e.nm = {nm, "_other"};
                drive(1'b0, 1'b1, (slot == 0), 1'b0, 4'hf, 4'hf, 4'h0, 4'h0, 1'b0, 10'h3ff, e);
            end
        end
    endtask

    initial begin
        exp_t e;
        eg.cen = 1'b0; eg.zero = 1'b0; eg.keyon = 1'b0;
        eg.arate = '0; eg.drate = '0; eg.rrate = '0; eg.sl = '0;
        eg.eg_type = 1'b0; eg.eg_in = '0;

        e.chk_out = 1; e.chk_cnt = 1;
        e.st = 2'd3; e.br = 5'd0; e.att = 1'b0; e.ke = 1'b0; e.nm = "reset";
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 10'h0, e);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 10'h0, e);

        //    k  ar    dr    rr    sl    et  eg_in   st    br     ke hold
        round(0, 4'hA, 4'h3, 4'h0, 4'h4, 1, 10'h3ff, 2'd3, 5'h00, 0, 0, "idle");
        round(1, 4'hA, 4'h3, 4'h0, 4'h4, 1, 10'h3ff, 2'd0, 5'h14, 1, 0, "kon");
        round(1, 4'hA, 4'h3, 4'h0, 4'h4, 1, 10'h100, 2'd0, 5'h14, 0, 1, "atk_hold");
        round(1, 4'hA, 4'h3, 4'h0, 4'h4, 1, 10'h000, 2'd1, 5'h06, 0, 0, "decay");
        round(1, 4'hA, 4'h3, 4'h0, 4'h4, 1, 10'h07f, 2'd1, 5'h06, 0, 0, "below_sl");
        round(1, 4'hA, 4'h3, 4'h0, 4'h4, 1, 10'h080, 2'd2, 5'h00, 0, 0, "sus_hold");
        round(1, 4'hA, 4'h3, 4'h7, 4'h4, 0, 10'h080, 2'd2, 5'h0E, 0, 0, "sus_rr");
        round(0, 4'hA, 4'h3, 4'h7, 4'h4, 0, 10'h080, 2'd3, 5'h0E, 0, 0, "koff");
        round(1, 4'hA, 4'h3, 4'h7, 4'h4, 0, 10'h3ff, 2'd0, 5'h14, 1, 0, "kon_above_sl");
        round(1, 4'hA, 4'h3, 4'h7, 4'hF, 1, 10'h000, 2'd1, 5'h06, 0, 0, "decay2");
        round(1, 4'hA, 4'h3, 4'h7, 4'hF, 1, 10'h3df, 2'd1, 5'h06, 0, 0, "sl15_below");
        round(1, 4'hA, 4'h3, 4'h7, 4'hF, 1, 10'h3e0, 2'd2, 5'h00, 0, 0, "sl15_sus");
        round(0, 4'hA, 4'h3, 4'h7, 4'hF, 1, 10'h3e0, 2'd3, 5'h0E, 0, 0, "koff2");
        round(1, 4'hA, 4'h3, 4'h7, 4'hF, 1, 10'h3ff, 2'd0, 5'h14, 1, 0, "kon3");
        round(0, 4'hA, 4'h3, 4'h5, 4'hF, 1, 10'h000, 2'd3, 5'h0A, 0, 0, "koff_atk_zero");
        round(0, 4'hA, 4'h3, 4'h0, 4'hF, 1, 10'h000, 2'd3, 5'h00, 0, 0, "rel_idle");

        // Counter preload: zero on every cen so each edge counts.
        e.chk_out = 0; e.st = 2'd3; e.br = 5'd0; e.att = 1'b0; e.ke = 1'b0;
        while (cnt_exp != 15'h7ffe) begin
            e.chk_cnt = 0; e.nm = "preload";
            drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 10'h3ff, e);
        end
        e.chk_cnt = 1; e.nm = "cnt_max";
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 10'h3ff, e);
        e.nm = "cnt_wrap";
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 10'h3ff, e);
        e.nm = "cnt_cen0";
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 10'h3ff, e);
        e.nm = "cnt_nozero";
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 10'h3ff, e);

        repeat (3) @(posedge clk);
        #3;
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
